// File: rtl/boot_image_loader.sv
// Boot image loader: copies a length-prefixed image from flash into IMEM over Wishbone while stalling the core.
// Optional trailing checksum verification is compiled in with `define BOOT_IMAGE_CHECKSUM_EN.
module boot_image_loader #(
    parameter int          IMEM_DEPTH     = 128,
    parameter logic [31:0] SRC_BASE       = 32'h2000_0000,
    parameter logic [31:0] DST_BASE       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        core_hold,
    output logic        boot_done,
    output logic        boot_err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        DAT_RD,
        DAT_WR,
`ifdef BOOT_IMAGE_CHECKSUM_EN
        CSUM_RD,
`endif
        DONE,
        FAIL
    } state_t;

    localparam logic [31:0] DEPTH_W  = 32'(IMEM_DEPTH);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic        cyc_n, we_n;
    logic [3:0]  sel_n;
    logic [31:0] adr_n, dat_n;
    logic [1:0]  err_code_n;
    logic [31:0] len, len_n;
    logic [31:0] word_cnt, word_cnt_n;
    logic [31:0] tmo_cnt, tmo_cnt_n;
    logic        bus_fault;
`ifdef BOOT_IMAGE_CHECKSUM_EN
    logic [31:0] csum, csum_n;
`endif

    assign wb_stb_o  = wb_cyc_o;
    assign core_hold = (state != DONE) && (state != FAIL);
    assign boot_done = (state == DONE);
    assign boot_err  = (state == FAIL);
    // err beats a simultaneous ack; a timeout only fires on a cycle that was not acked
    assign bus_fault = wb_err_i || (!wb_ack_i && (tmo_cnt == TMO_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_adr_o <= 32'd0;
            wb_dat_o <= 32'd0;
            err_code <= 2'd0;
            len      <= 32'd0;
            word_cnt <= 32'd0;
            tmo_cnt  <= 32'd0;
`ifdef BOOT_IMAGE_CHECKSUM_EN
            csum     <= 32'd0;
`endif
        end else begin
            state    <= state_n;
            wb_cyc_o <= cyc_n;
            wb_we_o  <= we_n;
            wb_sel_o <= sel_n;
            wb_adr_o <= adr_n;
            wb_dat_o <= dat_n;
            err_code <= err_code_n;
            len      <= len_n;
            word_cnt <= word_cnt_n;
            tmo_cnt  <= tmo_cnt_n;
`ifdef BOOT_IMAGE_CHECKSUM_EN
            csum     <= csum_n;
`endif
        end
    end

    // A bus state first spends one cycle with cyc low (the mandatory gap), then raises cyc and waits.
    always_comb begin
        state_n    = state;
        cyc_n      = wb_cyc_o;
        we_n       = wb_we_o;
        sel_n      = wb_sel_o;
        adr_n      = wb_adr_o;
        dat_n      = wb_dat_o;
        err_code_n = err_code;
        len_n      = len;
        word_cnt_n = word_cnt;
        tmo_cnt_n  = tmo_cnt;
`ifdef BOOT_IMAGE_CHECKSUM_EN
        csum_n     = csum;
`endif
        if (wb_cyc_o) begin
            tmo_cnt_n = tmo_cnt + 32'd1;
            if (bus_fault || wb_ack_i) begin
                cyc_n = 1'b0;
                we_n  = 1'b0;
                sel_n = 4'h0;
            end
            if (bus_fault) begin
                state_n    = FAIL;
                err_code_n = 2'd2;
            end else if (wb_ack_i) begin
                case (state)
                    HDR_RD: begin
                        if ((wb_dat_i == 32'd0) || (wb_dat_i > DEPTH_W)) begin
                            state_n    = FAIL;
                            err_code_n = 2'd1;
                        end else begin
                            len_n      = wb_dat_i;
                            word_cnt_n = 32'd0;
                            state_n    = DAT_RD;
                        end
                    end
                    DAT_RD: begin
                        dat_n   = wb_dat_i;
`ifdef BOOT_IMAGE_CHECKSUM_EN
                        csum_n  = csum + wb_dat_i;
`endif
                        state_n = DAT_WR;
                    end
                    DAT_WR: begin
                        if (word_cnt == len - 32'd1) begin
`ifdef BOOT_IMAGE_CHECKSUM_EN
                            state_n = CSUM_RD;
`else
                            state_n = DONE;
`endif
                        end else begin
                            word_cnt_n = word_cnt + 32'd1;
                            state_n    = DAT_RD;
                        end
                    end
`ifdef BOOT_IMAGE_CHECKSUM_EN
                    CSUM_RD: begin
                        if (wb_dat_i == csum) begin
                            state_n = DONE;
                        end else begin
                            state_n    = FAIL;
                            err_code_n = 2'd3;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end else begin
            case (state)
                IDLE: state_n = HDR_RD;
                HDR_RD: begin
                    cyc_n      = 1'b1;
                    we_n       = 1'b0;
                    sel_n      = 4'hF;
                    adr_n      = SRC_BASE;
                    tmo_cnt_n  = 32'd0;
                    word_cnt_n = 32'd0;
`ifdef BOOT_IMAGE_CHECKSUM_EN
                    csum_n     = 32'd0;
`endif
                end
                DAT_RD: begin
                    cyc_n     = 1'b1;
                    we_n      = 1'b0;
                    sel_n     = 4'hF;
                    adr_n     = SRC_BASE + 32'd4 + {word_cnt[29:0], 2'b00};
                    tmo_cnt_n = 32'd0;
                end
                DAT_WR: begin
                    cyc_n     = 1'b1;
                    we_n      = 1'b1;
                    sel_n     = 4'hF;
                    adr_n     = DST_BASE + {word_cnt[29:0], 2'b00};
                    tmo_cnt_n = 32'd0;
                end
`ifdef BOOT_IMAGE_CHECKSUM_EN
                CSUM_RD: begin
                    cyc_n     = 1'b1;
                    we_n      = 1'b0;
                    sel_n     = 4'hF;
                    adr_n     = SRC_BASE + 32'd4 + {len[29:0], 2'b00};
                    tmo_cnt_n = 32'd0;
                end
`endif
                DONE, FAIL: begin
                    if (start) begin
                        state_n    = HDR_RD;
                        err_code_n = 2'd0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
